// File: rtl/audio_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : audio_rx_pkg
// Brief    : Shared FSM encoding, default widths and channel constants.
// Revision : 1.0
// ============================================================================
package audio_rx_pkg;

    localparam int   c_BIT_DEPTH_DEF = 16;
    localparam int   c_SLOT_MAX_DEF  = 32;

    localparam logic c_CH_LEFT  = 1'b0;
    localparam logic c_CH_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_LEFT  = 2'd2,
        ST_RIGHT = 2'd3
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/audio_rx_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : audio_rx_sync_edge
// Brief    : Two-flop synchronizers plus history stage for BCLK/LRCLK/SDATA.
// Revision : 1.0
// ============================================================================
module audio_rx_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_bclk,
    input  logic i_lrclk,
    input  logic i_sdata,
    output logic o_lrclk,
    output logic o_sdata,
    output logic o_brise
);

    logic [1:0] r_bclk_sync;
    logic [1:0] r_lr_sync;
    logic [1:0] r_sd_sync;
    logic       r_bclk_hist;
    logic       r_lr_hist;
    logic       r_sd_hist;
    logic       r_brise;

    // LRCLK/SDATA history flops carry the value seen on the rising-edge cycle,
    // so they line up with the registered strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bclk_sync <= '0;
            r_lr_sync   <= '0;
            r_sd_sync   <= '0;
            r_bclk_hist <= 1'b0;
            r_lr_hist   <= 1'b0;
            r_sd_hist   <= 1'b0;
            r_brise     <= 1'b0;
        end else begin
            r_bclk_sync <= {r_bclk_sync[0], i_bclk};
            r_lr_sync   <= {r_lr_sync[0], i_lrclk};
            r_sd_sync   <= {r_sd_sync[0], i_sdata};
            r_bclk_hist <= r_bclk_sync[1];
            r_lr_hist   <= r_lr_sync[1];
            r_sd_hist   <= r_sd_sync[1];
            r_brise     <= r_bclk_sync[1] & ~r_bclk_hist;
        end
    end

    assign o_lrclk = r_lr_hist;
    assign o_sdata = r_sd_hist;
    assign o_brise = r_brise;

endmodule
`default_nettype wire

// File: rtl/audio_rx_i2s.sv
`default_nettype none
// ============================================================================
// Module   : audio_rx_i2s
// Brief    : I2S slave receiver producing stereo PCM words with error flags.
// Revision : 1.0
// ============================================================================
module audio_rx_i2s
    import audio_rx_pkg::*;
#(
    parameter int pBitDepth = c_BIT_DEPTH_DEF,
    parameter int pSlotMax  = c_SLOT_MAX_DEF
) (
    input  logic                   iMCLK,
    input  logic                   iMRST,
    input  logic                   iI2S_BCLK,
    input  logic                   iI2S_LRCLK,
    input  logic                   iI2S_SDATA,
    input  logic                   iEn,
    output logic [2*pBitDepth-1:0] oRd,
    output logic                   oRvd,
    input  logic                   iRe,
    output logic                   oOverrun,
    output logic                   oFrameErr,
    input  logic                   iErrClr
);

    localparam int              c_CW       = $clog2(pSlotMax + 1);
    localparam logic [c_CW-1:0] c_CNT_SAT  = c_CW'(pSlotMax + 1);
    localparam logic [c_CW-1:0] c_DEPTH    = c_CW'(pBitDepth);
    localparam logic [c_CW-1:0] c_SLOT_MAX = c_CW'(pSlotMax);

    logic                   w_lr;
    logic                   w_sd;
    logic                   w_brise;

    rx_state_t              r_state;
    logic                   r_wsd;
    logic [pBitDepth-1:0]   r_shift;
    logic [pBitDepth-1:0]   r_left;
    logic [c_CW-1:0]        r_bitcnt;
    logic                   r_done;
    logic [2*pBitDepth-1:0] r_done_word;
    logic                   r_ferr_set;

    logic [2*pBitDepth-1:0] r_rd;
    logic                   r_rvd;
    logic                   r_ovr;
    logic                   r_ferr;

    logic                   w_capture;
    logic [pBitDepth-1:0]   w_shift_nxt;
    logic [c_CW-1:0]        w_cnt_nxt;
    logic                   w_boundary;
    logic                   w_slot_ok;
    logic                   w_ovr_set;

    audio_rx_sync_edge u_sync (
        .clk     (iMCLK),
        .rst     (iMRST),
        .i_bclk  (iI2S_BCLK),
        .i_lrclk (iI2S_LRCLK),
        .i_sdata (iI2S_SDATA),
        .o_lrclk (w_lr),
        .o_sdata (w_sd),
        .o_brise (w_brise)
    );

    // Next shift/count include the bit on the current edge, so a boundary
    // edge sees the closing slot complete with its LSB.
    assign w_capture   = (r_bitcnt < c_DEPTH);
    assign w_shift_nxt = w_capture ? {r_shift[pBitDepth-2:0], w_sd} : r_shift;
    assign w_cnt_nxt   = (r_bitcnt == c_CNT_SAT) ? c_CNT_SAT : r_bitcnt + c_CW'(1);
    assign w_boundary  = w_brise & (w_lr != r_wsd);
    assign w_slot_ok   = (w_cnt_nxt >= c_DEPTH) && (w_cnt_nxt <= c_SLOT_MAX);
    assign w_ovr_set   = r_done & r_rvd & ~iRe;

    always_ff @(posedge iMCLK) begin
        if (iMRST) begin
            r_state     <= ST_IDLE;
            r_wsd       <= c_CH_LEFT;
            r_shift     <= '0;
            r_left      <= '0;
            r_bitcnt    <= '0;
            r_done      <= 1'b0;
            r_done_word <= '0;
            r_ferr_set  <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_ferr_set <= 1'b0;
            if (w_brise) begin
                r_wsd <= w_lr;
            end
            if (!iEn) begin
                r_state  <= ST_IDLE;
                r_shift  <= '0;
                r_left   <= '0;
                r_bitcnt <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: r_state <= ST_SYNC;
                    ST_SYNC: begin
                        if (w_boundary && r_wsd == c_CH_RIGHT && w_lr == c_CH_LEFT) begin
                            r_state <= ST_LEFT;
                        end
                    end
                    ST_LEFT, ST_RIGHT: begin
                        if (w_boundary) begin
                            if (!w_slot_ok) begin
                                r_ferr_set <= 1'b1;
                                r_state    <= ST_SYNC;
                            end else if (r_state == ST_LEFT) begin
                                r_left  <= w_shift_nxt;
                                r_state <= ST_RIGHT;
                            end else begin
                                r_done      <= 1'b1;
                                r_done_word <= {r_left, w_shift_nxt};
                                r_state     <= ST_LEFT;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
                if (w_brise) begin
                    if (w_boundary || r_state == ST_IDLE || r_state == ST_SYNC) begin
                        r_shift  <= '0;
                        r_bitcnt <= '0;
                    end else begin
                        r_shift  <= w_shift_nxt;
                        r_bitcnt <= w_cnt_nxt;
                    end
                end
            end
        end
    end

    // A new frame may replace the held word only in the cycle it is accepted.
    always_ff @(posedge iMCLK) begin
        if (iMRST) begin
            r_rd   <= '0;
            r_rvd  <= 1'b0;
            r_ovr  <= 1'b0;
            r_ferr <= 1'b0;
        end else begin
            if (r_rvd && iRe) begin
                r_rvd <= 1'b0;
            end
            if (r_done && (!r_rvd || iRe)) begin
                r_rd  <= r_done_word;
                r_rvd <= 1'b1;
            end
            if (w_ovr_set) begin
                r_ovr <= 1'b1;
            end else if (iErrClr) begin
                r_ovr <= 1'b0;
            end
            if (r_ferr_set) begin
                r_ferr <= 1'b1;
            end else if (iErrClr) begin
                r_ferr <= 1'b0;
            end
        end
    end

    assign oRd       = r_rd;
    assign oRvd      = r_rvd;
    assign oOverrun  = r_ovr;
    assign oFrameErr = r_ferr;

endmodule
`default_nettype wire

// File: tb/tb_audio_rx_i2s.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_rx_i2s
// Brief    : Directed I2S stimulus against a slot-level receive model.
// Revision : 1.0
// ============================================================================
module tb_audio_rx_i2s;

    localparam int M_IDLE  = 0;
    localparam int M_SYNC  = 1;
    localparam int M_LEFT  = 2;
    localparam int M_RIGHT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        bclk;
    logic        lrclk;
    logic        sdata;
    logic        en;
    logic        re;
    logic        errclr;
    logic [31:0] rd;
    logic        rvd;
    logic        ovr;
    logic        ferr;

    int          n_chk  = 0;
    int          n_pass = 0;

    logic [31:0] exp_q[$];
    int          mstate = M_IDLE;
    logic [15:0] mleft  = '0;
    bit          m_ovr  = 0;
    bit          m_ferr = 0;
    int          delivered = 0;
    logic [31:0] last_word = '0;
    bit          prev_xfer = 0;
    logic [31:0] cmp_exp;

    bit          have_pend = 0;
    logic        pend_sd   = 1'b0;

    always #5 clk = ~clk;

    audio_rx_i2s #(.pBitDepth(16), .pSlotMax(32)) dut (
        .iMCLK      (clk),
        .iMRST      (rst),
        .iI2S_BCLK  (bclk),
        .iI2S_LRCLK (lrclk),
        .iI2S_SDATA (sdata),
        .iEn        (en),
        .oRd        (rd),
        .oRvd       (rvd),
        .iRe        (re),
        .oOverrun   (ovr),
        .oFrameErr  (ferr),
        .iErrClr    (errclr)
    );

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Slot-level model: called once per completed slot with its channel and length.
    function automatic void model_slot(input logic ch, input logic [31:0] d, input int n);
        bit ok;
        ok = (n >= 16) && (n <= 32);
        case (mstate)
            M_SYNC: if (ch == 1'b1) mstate = M_LEFT;
            M_LEFT: begin
                if (ok) begin mleft = d[31:16]; mstate = M_RIGHT; end
                else begin m_ferr = 1; mstate = M_SYNC; end
            end
            M_RIGHT: begin
                if (ok) begin
                    if (exp_q.size() != 0 && !re) m_ovr = 1;
                    else exp_q.push_back({mleft, d[31:16]});
                    mstate = M_LEFT;
                end else begin
                    m_ferr = 1; mstate = M_SYNC;
                end
            end
            default: ;
        endcase
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clock_bit(input logic lr, input logic sd);
        bclk = 1'b0; lrclk = lr; sdata = sd;
        cyc(4);
        bclk = 1'b1;
        cyc(4);
    endtask

    // One-bit I2S delay: a data bit goes out with the LRCLK of the bit after it.
    task automatic tx_bit(input logic lr, input logic sd);
        if (have_pend) clock_bit(lr, pend_sd);
        pend_sd = sd;
        have_pend = 1;
    endtask

    task automatic flush();
        if (have_pend) clock_bit(1'b0, pend_sd);
        have_pend = 0;
    endtask

    task automatic push_bits(input logic ch, input logic [31:0] d, input int lo, input int hi);
        for (int i = lo; i < hi; i++) tx_bit(ch, d[31-i]);
    endtask

    task automatic push_slot(input logic ch, input logic [31:0] d, input int n);
        push_bits(ch, d, 0, n);
        model_slot(ch, d, n);
    endtask

    task automatic set_en(input logic v);
        en = v;
        if (!v) mstate = M_IDLE;
        else if (mstate == M_IDLE) mstate = M_SYNC;
    endtask

    task automatic err_clear();
        errclr = 1'b1; m_ovr = 0; m_ferr = 0;
        cyc(1);
        errclr = 1'b0;
        cyc(1);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_xfer = 0;
        end else begin
            if (rvd) begin
                cmp_exp = (exp_q.size() != 0) ? exp_q[0] : 32'hxxxx_xxxx;
                check(exp_q.size() != 0 && rd === cmp_exp, "rd_vs_model", rd, cmp_exp);
            end
            if (rvd && re) begin
                check(!prev_xfer, "rvd_single_cycle", {31'b0, prev_xfer}, 32'h0);
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                delivered++;
                last_word = rd;
            end
            prev_xfer = rvd && re;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; re = 1'b1; errclr = 1'b0;
        bclk = 1'b0; lrclk = 1'b0; sdata = 1'b0;
        cyc(5);
        check(rd == 32'h0, "reset_rd", rd, 32'h0);
        check(rvd == 1'b0, "reset_rvd", {31'b0, rvd}, 32'h0);
        check(ovr == 1'b0, "reset_ovr", {31'b0, ovr}, 32'h0);
        check(ferr == 1'b0, "reset_ferr", {31'b0, ferr}, 32'h0);
        rst = 1'b0;
        cyc(2);

        // Basic frame with 32-bit slots, downstream always ready
        set_en(1'b1);
        cyc(2);
        push_slot(1'b1, 32'h0000_0000, 32);
        push_slot(1'b0, 32'h1234_0000, 32);
        push_slot(1'b1, 32'hABCD_0000, 32);
        check(exp_q.size() == 1 && exp_q[0] == 32'h1234ABCD, "model_pin_s1", exp_q.size() != 0 ? exp_q[0] : 32'h0, 32'h1234ABCD);
        flush();
        cyc(40);
        check(exp_q.size() == 0, "s1_delivered", exp_q.size(), 32'h0);
        check(last_word == 32'h1234ABCD, "s1_word", last_word, 32'h1234ABCD);
        check(rvd == 1'b0, "s1_rvd_low", {31'b0, rvd}, 32'h0);
        check(ferr == 1'b0, "s1_ferr", {31'b0, ferr}, 32'h0);

        // Enable in the middle of a garbage right slot
        set_en(1'b0);
        cyc(4);
        push_bits(1'b1, 32'hDEAD_BEEF, 0, 10);
        set_en(1'b1);
        push_bits(1'b1, 32'hDEAD_BEEF, 10, 20);
        model_slot(1'b1, 32'hDEAD_BEEF, 20);
        push_slot(1'b0, 32'h8001_0000, 32);
        push_slot(1'b1, 32'h7FFE_0000, 32);
        flush();
        cyc(40);
        check(last_word == 32'h80017FFE, "s2_word", last_word, 32'h80017FFE);
        check(delivered == 2, "s2_count", delivered, 32'd2);
        check(ferr == 1'b0, "s2_ferr", {31'b0, ferr}, 32'h0);

        // Three frames with downstream stalled
        re = 1'b0;
        push_slot(1'b0, 32'h1111_0000, 32);
        push_slot(1'b1, 32'h2222_0000, 32);
        push_slot(1'b0, 32'h3333_0000, 32);
        push_slot(1'b1, 32'h4444_0000, 32);
        push_slot(1'b0, 32'h5555_0000, 32);
        push_slot(1'b1, 32'h6666_0000, 32);
        flush();
        cyc(40);
        check(exp_q.size() == 1 && m_ovr, "model_pin_s3", exp_q.size(), 32'd1);
        check(rvd == 1'b1, "s3_rvd_held", {31'b0, rvd}, 32'h1);
        check(rd == 32'h11112222, "s3_word_held", rd, 32'h11112222);
        check(ovr == 1'b1, "s3_overrun", {31'b0, ovr}, 32'h1);
        err_clear();
        check(ovr == m_ovr, "s3_overrun_clr", {31'b0, ovr}, {31'b0, m_ovr});
        re = 1'b1;
        cyc(3);
        check(delivered == 3, "s3_count", delivered, 32'd3);
        check(rvd == 1'b0, "s3_rvd_low", {31'b0, rvd}, 32'h0);

        // Short left slot, then a good frame
        push_slot(1'b0, 32'hABC0_0000, 12);
        push_slot(1'b1, 32'h5555_5555, 32);
        push_slot(1'b0, 32'h0F0F_0000, 32);
        push_slot(1'b1, 32'hF0F0_0000, 32);
        flush();
        cyc(40);
        check(ferr == 1'b1, "s4_frame_err", {31'b0, ferr}, 32'h1);
        check(ferr == m_ferr, "s4_ferr_model", {31'b0, ferr}, {31'b0, m_ferr});
        check(last_word == 32'h0F0FF0F0, "s4_word", last_word, 32'h0F0FF0F0);
        check(delivered == 4, "s4_count", delivered, 32'd4);
        err_clear();
        check(ferr == 1'b0, "s4_ferr_clr", {31'b0, ferr}, 32'h0);

        // Disable during a left slot while a word is pending
        re = 1'b0;
        push_slot(1'b0, 32'h2468_0000, 32);
        push_slot(1'b1, 32'h1357_0000, 32);
        flush();
        cyc(40);
        check(rvd == 1'b1, "s5_pending", {31'b0, rvd}, 32'h1);
        push_bits(1'b0, 32'hCAFE_0000, 0, 10);
        set_en(1'b0);
        push_bits(1'b0, 32'hCAFE_0000, 10, 32);
        model_slot(1'b0, 32'hCAFE_0000, 32);
        push_slot(1'b1, 32'hBEEF_0000, 32);
        flush();
        cyc(40);
        check(rvd == 1'b1, "s5_still_pending", {31'b0, rvd}, 32'h1);
        check(rd == 32'h24681357, "s5_word_held", rd, 32'h24681357);
        check(ovr == 1'b0, "s5_no_overrun", {31'b0, ovr}, 32'h0);
        re = 1'b1;
        cyc(3);
        check(delivered == 5, "s5_count", delivered, 32'd5);
        check(last_word == 32'h24681357, "s5_word", last_word, 32'h24681357);
        cyc(20);
        check(rvd == 1'b0, "s5_no_more", {31'b0, rvd}, 32'h0);

        // Reset in the middle of a right slot
        set_en(1'b1);
        push_slot(1'b1, 32'h0000_0000, 32);
        push_slot(1'b0, 32'hCAFE_0000, 32);
        push_bits(1'b1, 32'h1234_5678, 0, 10);
        rst = 1'b1;
        exp_q.delete();
        m_ovr = 0; m_ferr = 0; mstate = M_IDLE;
        set_en(1'b0);
        cyc(1);
        check(rd == 32'h0, "s6_rst_rd", rd, 32'h0);
        check(rvd == 1'b0, "s6_rst_rvd", {31'b0, rvd}, 32'h0);
        check(ovr == 1'b0, "s6_rst_ovr", {31'b0, ovr}, 32'h0);
        check(ferr == 1'b0, "s6_rst_ferr", {31'b0, ferr}, 32'h0);
        rst = 1'b0;
        cyc(2);
        set_en(1'b1);
        push_bits(1'b1, 32'h1234_5678, 10, 32);
        model_slot(1'b1, 32'h1234_5678, 32);
        push_slot(1'b0, 32'h600D_0000, 32);
        push_slot(1'b1, 32'hBEEF_0000, 32);
        flush();
        cyc(40);
        check(last_word == 32'h600DBEEF, "s6_word", last_word, 32'h600DBEEF);
        check(delivered == 6, "s6_count", delivered, 32'd6);
        check(exp_q.size() == 0, "s6_drained", exp_q.size(), 32'h0);
        check(ferr == 1'b0 && ovr == 1'b0, "s6_flags", {30'b0, ovr, ferr}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
